// File: rtl/imem_port_ctrl.sv
// imem_port_ctrl: shares a byte-wide instruction memory between core fetch (1-cycle registered reads)
// and a program loader (32-bit writes as four byte beats). Optional macro IMEM_ALIGN_CHK_EN adds fetch_err.
module imem_port_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
`ifdef IMEM_ALIGN_CHK_EN
  ,
  output logic              fetch_err
`endif
);

  localparam int unsigned STREAK_W = $clog2(MAX_LD_BURST + 1);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ld_done_q, ld_done_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fetch_starved;

`ifdef IMEM_ALIGN_CHK_EN
  logic err_q, err_d;
  logic misaligned;

  assign misaligned = (addr_q[1:0] != 2'b00);
  assign fetch_err  = err_q;
`endif

  // Fetch overrides the loader only once the loader has won MAX_LD_BURST times in a row over it.
  assign fetch_starved = fetch_req && (streak_q == STREAK_W'(MAX_LD_BURST));

  assign busy         = (state_q != IDLE);
  assign ld_done      = ld_done_q;
  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rdata_q;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_done_d = 1'b0;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
`ifdef IMEM_ALIGN_CHK_EN
    err_d     = err_q;
`endif
    ld_gnt    = 1'b0;
    fetch_gnt = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (ld_req && !fetch_starved) begin
          state_d  = WR;
          beat_d   = 2'd0;
          addr_d   = ld_addr;
          wdata_d  = ld_wdata;
          streak_d = fetch_req ? streak_q + STREAK_W'(1) : '0;
        end else if (fetch_req) begin
          state_d  = RD;
          addr_d   = fetch_addr;
          streak_d = '0;
        end
      end

      WR: begin
        ld_gnt    = (beat_q == 2'd0);
        mem_we    = 1'b1;
        mem_addr  = addr_q + ADDR_W'(beat_q);
        mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        if (beat_q == 2'd3) begin
          state_d   = IDLE;
          beat_d    = 2'd0;
          ld_done_d = 1'b1;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end

      RD: begin
        fetch_gnt = 1'b1;
        mem_addr  = addr_q;
        rvalid_d  = 1'b1;
        rdata_d   = mem_rdata;
`ifdef IMEM_ALIGN_CHK_EN
        if (misaligned) begin
          mem_addr = '0;
          rdata_d  = NOP_INSN;
        end
        err_d = misaligned;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the memory array lives outside this block; only control and latch registers take the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      streak_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_done_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef IMEM_ALIGN_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of its peers.
      state_q   <= state_d;
      beat_q    <= beat_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_done_q <= ld_done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
`ifdef IMEM_ALIGN_CHK_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: doc/imem_port_ctrl.md
Name: imem_port_ctrl

Overview:
- Single-port controller that shares the byte-wide instruction memory between two requesters: core instruction fetch and a program loader.
- The memory is a byte array with a combinational, little-endian 32-bit read at mem_addr and a one-byte write.
- The controller sequences 32-bit loader writes as four byte beats and serves fetch reads with a registered 1-cycle response.
- Arbitration gives the loader priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 32, width of all byte addresses
MAX_LD_BURST, 4, maximum consecutive loader grants while fetch is waiting before fetch wins once

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  fetch request; held with fetch_addr until fetch_gnt
fetch_addr  input  ADDR_W  byte address of the instruction
fetch_gnt  output  1  1-cycle pulse: fetch accepted, memory read this cycle
fetch_rvalid  output  1  1-cycle pulse: fetch_rdata valid
fetch_rdata  output  32  fetched instruction; holds until the next rvalid
ld_req  input  1  loader write request; held with ld_addr/ld_wdata until ld_gnt
ld_addr  input  ADDR_W  byte address of the word's least-significant byte
ld_wdata  input  32  word to write, little-endian
ld_gnt  output  1  1-cycle pulse: write accepted (first beat cycle)
ld_done  output  1  1-cycle pulse: all four bytes written
mem_addr  output  ADDR_W  byte address to the memory
mem_we  output  1  byte write enable
mem_wdata  output  8  write byte
mem_rdata  input  32  combinational read {m[a+3],m[a+2],m[a+1],m[a]}
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beat=0; ld_streak=0.
  - All outputs 0, including fetch_rdata. Address/data latches cleared.
  - Reset mid-write abandons the remaining beats: no ld_done, and bytes already written stay written.
- States: IDLE, WR (beat 0..3), RD.
- IDLE decision at each rising edge:
  - Loader wins if ld_req=1, unless fetch_req=1 and ld_streak==MAX_LD_BURST; in that case fetch wins.
  - Otherwise fetch wins if fetch_req=1. Otherwise stay in IDLE.
  - Loader win: latch ld_addr/ld_wdata, go to WR beat 0. ld_streak increments if fetch_req=1, else clears to 0.
  - Fetch win: latch fetch_addr, go to RD. ld_streak clears to 0.
- WR:
  - ld_gnt=1 only in the beat-0 cycle.
  - Each beat drives mem_we=1, mem_addr=addr_q+beat (mod 2^ADDR_W, wraps), mem_wdata=wdata_q[8*beat+7:8*beat].
  - After beat 3, go to IDLE. ld_done=1 in that first IDLE cycle, which may also accept a new request.
  - Write latency: accept edge E0; beats occupy cycles 1–4; ld_done in cycle 5.
- RD:
  - One cycle: fetch_gnt=1, mem_we=0, mem_addr=fetch_addr_q.
  - fetch_rdata<=mem_rdata at the end of the RD cycle; fetch_rvalid=1 in the following cycle.
  - Fetch latency: accept edge E0; rvalid in cycle 2.
- In IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
- Requesters must deassert or change their request only after seeing gnt. Because the FSM is out of IDLE during the gnt cycle, a held request cannot be accepted twice.
- No address range checking. Out-of-range behaviour belongs to the memory.

Optional Feature:
IMEM_ALIGN_CHK_EN
- Defined:
  - Extra output fetch_err (1 bit, reset 0).
  - A fetch accepted with fetch_addr_q[1:0]!=0 still passes through RD with fetch_gnt, but mem_addr is forced to 0.
  - fetch_rdata becomes 32'h00000013 (NOP) and fetch_err=1, coincident with fetch_rvalid.
  - Aligned fetches return fetch_err=0.
- Undefined: no fetch_err port, and misaligned addresses read unchanged.

Test Plan:
- Single write: ld_addr=0x34, ld_wdata=0x001020A3 -> beats write 0x34=A3, 0x35=20, 0x36=10, 0x37=00; ld_gnt at cycle 1, ld_done at cycle 5; busy high for cycles 1–4.
- Fetch after load: write 0x00400093 to 0x4, then fetch 0x4 -> fetch_gnt at cycle 1, fetch_rvalid at cycle 2 with fetch_rdata=0x00400093.
- Simultaneous request, ld_streak=0: ld_req and fetch_req both held -> loader granted first; fetch granted in the IDLE cycle carrying ld_done; rdata correct.
- Starvation: 6 back-to-back loader words with fetch_req held, MAX_LD_BURST=4 -> grant order L,L,L,L,F,L,L; exactly one fetch_rvalid.
- Async reset at beat 2 of a write to 0x10 (data 0xAABBCCDD) -> bytes 0x10=DD and 0x11=CC written, 0x12/0x13 untouched; no ld_done; all outputs 0 immediately; normal operation after release.
- With IMEM_ALIGN_CHK_EN: fetch 0x6 -> fetch_rvalid with fetch_rdata=0x00000013 and fetch_err=1; fetch 0x8 -> fetch_err=0.
